// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer: walks a buffer of CHANNELS maps in 2x2 windows. Each
// window gets four source reads, the external pool unit accumulates the returned
// pixels, and the pooled result is written to the window index.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request to pool the whole buffer (honoured only when idle)
//   busy, done      job active / one-cycle completion pulse
//   rd_en, rd_addr  source read strobe and pixel address (data returns next cycle)
//   pool_reset      zeroes the pool unit (high whenever idle, incl. the accept cycle)
//   pool_run        pool unit compare-and-accumulate, aligned with returned data
//   pool_clear      pool unit window close
//   pool_result     pool unit registered result
//   wr_en, wr_addr, wr_data  destination write of one pooled value
module pool_window_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned CHANNELS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         pool_reset,
  output logic                         pool_run,
  output logic                         pool_clear,
  input  logic signed [DATA_WIDTH-1:0] pool_result,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned N_WIN = CHANNELS * (IMG_W / 2) * (IMG_H / 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_WIN = ADDR_WIDTH'(N_WIN - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] ROW_OFF  = ADDR_WIDTH'(IMG_W);
  // From the last window of a row pair to the first of the next pair (or of the
  // next channel, which is the same stride since maps are stored back-to-back).
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            phase_q, phase_d;   // slot within the 5-cycle window period
  logic [ADDR_WIDTH-1:0] base_q, base_d;     // top-left pixel address of current window
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] win_q, win_d;       // window being read
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d; // next destination index
  logic                  rd_en_d, pool_clear_d, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d, wr_addr_d;
  logic signed [DATA_WIDTH-1:0] wr_hold_q;

  // Next-state, counter and next-cycle strobe logic
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    base_d       = base_q;
    col_d        = col_q;
    win_d        = win_q;
    wr_cnt_d     = wr_cnt_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr;
    pool_clear_d = 1'b0;
    wr_addr_d    = wr_addr;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          phase_d  = 3'd0;
          base_d   = '0;
          col_d    = '0;
          win_d    = '0;
          wr_cnt_d = '0;
        end
      end
      FETCH: begin
        phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd3) begin
          if (win_q == LAST_WIN) begin
            state_d = DRAIN;
          end else begin
            win_d = win_q + ADDR_WIDTH'(1);
            if (col_q == LAST_COL) begin
              col_d  = '0;
              base_d = base_q + ROW_STEP;
            end else begin
              col_d  = col_q + ADDR_WIDTH'(2);
              base_d = base_q + ADDR_WIDTH'(2);
            end
          end
        end
      end
      DRAIN: begin
        phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        if (wr_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Slots 0..3 read (r,c),(r,c+1),(r+1,c),(r+1,c+1); slot 4 is idle
    if (state_d == FETCH && phase_d != 3'd4) begin
      rd_en_d   = 1'b1;
      rd_addr_d = base_d + (phase_d[1] ? ROW_OFF : '0) + ADDR_WIDTH'(phase_d[0]);
    end

    // A run in slot 4 is the window's fourth sample; close it next cycle
    pool_clear_d = pool_run && (phase_q == 3'd4);
    if (pool_clear_d) begin
      wr_addr_d = wr_cnt_q;
      wr_cnt_d  = wr_cnt_q + ADDR_WIDTH'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      base_q     <= '0;
      col_q      <= '0;
      win_q      <= '0;
      wr_cnt_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pool_reset <= 1'b1;
      pool_run   <= 1'b0;
      pool_clear <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      base_q     <= base_d;
      col_q      <= col_d;
      win_q      <= win_d;
      wr_cnt_q   <= wr_cnt_d;
      busy       <= (state_d != IDLE);
      done       <= done_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      pool_reset <= (state_d == IDLE);
      pool_run   <= rd_en;
      pool_clear <= pool_clear_d;
      wr_en      <= pool_clear_d;
      wr_addr    <= wr_addr_d;
      if (wr_en) wr_hold_q <= pool_result;
    end
  end

  // pool_result is only final in the close cycle, so pass it through then and
  // hold the last written value otherwise.
  assign wr_data = wr_en ? pool_result : wr_hold_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Self-checking bench for pool_window_sequencer: 4x4 maps, two channels.
// The bench models the source memory and the pool unit; expected reads, writes
// and done timing are derived from window geometry and pushed to queues.
module tb_pool_window_sequencer;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CH = 2;
  localparam int NW = CH * (W / 2) * (H / 2);
  localparam int NPIX = CH * W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, rd_en, pool_reset, pool_run, pool_clear, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic signed [DW-1:0] pool_result, wr_data;

  pool_window_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H), .CHANNELS(CH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .pool_reset(pool_reset),
    .pool_run(pool_run), .pool_clear(pool_clear), .pool_result(pool_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: source memory with one-cycle read latency and a max pool unit
  logic signed [DW-1:0] mem [NPIX];
  logic signed [DW-1:0] rd_data = '0;
  logic signed [DW-1:0] acc = '0;
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[int'(rd_addr) % NPIX];
    if (pool_reset || pool_clear) acc <= '0;
    else if (pool_run && rd_data > acc) acc <= rd_data;
  end
  assign pool_result = acc;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  int   done_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_done = 0;
  logic prev_rd_en = 1'b0;
  logic prev_reset = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe
  always @(negedge clk) begin
    exp_t e;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_addr", int'(rd_addr), e.addr);
        chk("rd_cycle", cyc, e.cyc);
      end
    end
    if (wr_en) begin
      n_wr++;
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      n_done++;
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
      chk("busy_at_done", int'(busy), 0);
    end
    chk("run_clear_overlap", int'(pool_run && pool_clear), 0);
    if (!prev_reset) chk("run_follows_rd", int'(pool_run), int'(prev_rd_en));
    prev_rd_en = rd_en;
    prev_reset = reset;
  end

  task automatic fill_mem(input bit directed);
    for (int i = 0; i < NPIX; i++) begin
      int tmp;
      tmp = int'($urandom_range(0, 400)) - 200;
      mem[i] = DW'(tmp);
    end
    if (directed) begin
      mem[0] = 16'sd3;  mem[1] = -16'sd7; mem[4] = 16'sd12; mem[5] = 16'sd5;
      mem[2] = -16'sd1; mem[3] = -16'sd4; mem[6] = -16'sd2; mem[7] = -16'sd9;
    end
  endtask

  // Reference: windows in channel/row/column order, ReLU'd max of 4 pixels
  task automatic push_expect(input int t0);
    int w;
    w = 0;
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < H; r += 2)
        for (int c = 0; c < W; c += 2) begin
          int base, m;
          int offs[4];
          base = ch * W * H + r * W + c;
          offs[0] = 0; offs[1] = 1; offs[2] = W; offs[3] = W + 1;
          m = 0;
          for (int k = 0; k < 4; k++) begin
            int v;
            rd_q.push_back('{addr: base + offs[k], data: 0, cyc: t0 + 1 + 5 * w + k});
            v = int'(mem[base + offs[k]]);
            if (v > m) m = v;
          end
          wr_q.push_back('{addr: w, data: m, cyc: t0 + 5 * w + 6});
          w++;
        end
    done_q.push_back(t0 + 5 * NW + 2);
  endtask

  task automatic launch(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    push_expect(t0);
    @(negedge clk);
    chk("pool_reset_accept", int'(pool_reset), 1);
    chk("busy_accept", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_rise", int'(busy), 1);
    chk("pool_reset_drop", int'(pool_reset), 0);
  endtask

  task automatic finish_job(input int wr0, input int done0);
    int guard;
    guard = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    chk("job_timeout", int'(guard < 200), 1);
    repeat (4) @(negedge clk);
    chk("write_count", n_wr - wr0, NW);
    chk("done_count", n_done - done0, 1);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int t0, wr0, done0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_pool_run", int'(pool_run), 0);
    chk("rst_pool_clear", int'(pool_clear), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_pool_reset", int'(pool_reset), 1);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Directed windows (max 12, all-negative -> 0) then random jobs
    for (int j = 0; j < 5; j++) begin
      fill_mem(j == 0);
      wr0 = n_wr; done0 = n_done;
      launch(t0);
      finish_job(wr0, done0);
    end

    // Second start mid-job must be ignored
    fill_mem(1'b0);
    wr0 = n_wr; done0 = n_done;
    launch(t0);
    while (cyc < t0 + 7) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_job(wr0, done0);

    // Reset in cycle 9 abandons the job; restart at cycle 12 begins at address 0
    fill_mem(1'b0);
    launch(t0);
    while (cyc < t0 + 9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    wr0 = n_wr; done0 = n_done;
    @(negedge clk);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_pool_run", int'(pool_run), 0);
    chk("abort_pool_clear", int'(pool_clear), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_quiet_rd", int'(rd_en), 0);
    chk("abort_quiet_wr", int'(wr_en), 0);
    chk("abort_writes", n_wr - wr0, 0);
    launch(t0);
    finish_job(wr0, done0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_window_sequencer.md
POOL_WINDOW_SEQUENCER -- requirements
Module: pool_window_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel/result width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, read/write address width; must hold CHANNELS*IMG_W*IMG_H-1.
REQ-003 SHALL have parameter IMG_W, default 28, input map width, even, >=2.
REQ-004 SHALL have parameter IMG_H, default 28, input map height, even, >=2.
REQ-005 SHALL have parameter CHANNELS, default 1, number of maps stored back-to-back.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  request to pool the whole buffer.
REQ-009 SHALL have port busy  output  1  high from start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rd_en  output  1  source memory read strobe, data returns next cycle.
REQ-012 SHALL have port rd_addr  output  ADDR_WIDTH  source pixel address.
REQ-013 SHALL have port pool_reset  output  1  zeroes pool unit accumulator and internal address.
REQ-014 SHALL have port pool_run  output  1  pool unit compare-and-accumulate strobe.
REQ-015 SHALL have port pool_clear  output  1  pool unit window-close strobe.
REQ-016 SHALL have port pool_result  input  DATA_WIDTH signed  pool unit registered result.
REQ-017 SHALL have port wr_en / wr_addr / wr_data  output  1 / ADDR_WIDTH / DATA_WIDTH  destination write.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start, FETCH->DRAIN after last read issued, DRAIN->IDLE after last write.
REQ-019 SHALL accept start only in IDLE; start while busy ignored, no effect on sequence.
REQ-020 SHALL assert pool_reset exactly in the acceptance cycle (cycle 0); busy rises cycle 1.
REQ-021 SHALL issue window reads with a 5-cycle period starting cycle 1: slots k=0..3 read, slot 4 idle.
REQ-022 SHALL order reads per window (r,c),(r,c+1),(r+1,c),(r+1,c+1), rd_addr = ch*IMG_W*IMG_H + row*IMG_W + col.
REQ-023 SHALL advance windows c+=2 across row, then r+=2, then ch+=1; total N = CHANNELS*(IMG_W/2)*(IMG_H/2).
REQ-024 SHALL assert pool_run = rd_en delayed one cycle (aligned with returned data).
REQ-025 SHALL assert pool_clear one cycle after each window's fourth pool_run; never simultaneous with pool_run.
REQ-026 SHALL assert wr_en in the pool_clear cycle with wr_data = pool_result, wr_addr = window index (0..N-1).
REQ-027 SHALL overlap next window's first read with current pool_clear cycle.
REQ-028 SHALL issue last write at cycle 5N+1, assert done and deassert busy at cycle 5N+2.
REQ-029 SHALL hold rd_addr, wr_addr, wr_data stable (don't-care content) when strobes low; strobes never X after reset.
REQ-030 SHALL accept a new start in the same cycle done is high only if state is IDLE (i.e. the cycle after done).

Reset
REQ-031 SHALL on reset force IDLE, busy=0, done=0, rd_en=0, pool_run=0, pool_clear=0, wr_en=0, pool_reset=1, rd_addr=0, wr_addr=0, all counters 0.
REQ-032 SHALL on reset mid-operation abandon the sequence with no further rd_en/wr_en; next start restarts from address 0.

Verification
REQ-033 W=H=4, CH=1, start at cycle 0 -> rd_addr 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15; wr_addr 0..3 at cycles 6,11,16,21; done at cycle 22.
REQ-034 Window pixels {3,-7,12,5} -> wr_data 12; all-negative {-1,-4,-2,-9} -> wr_data 0 (ReLU via zeroed accumulator).
REQ-035 W=H=4, CH=2 -> second-channel reads start at address 16, wr_addr 4..7, done at cycle 42.
REQ-036 start pulsed at cycles 0 and 7 -> second start ignored; exactly 4 writes, single done.
REQ-037 reset asserted at cycle 9 -> all strobes 0 from cycle 10; start at cycle 12 -> first rd_addr 0 at cycle 13.
REQ-038 Checker: every cycle assert !(pool_run && pool_clear) and pool_run == rd_en delayed 1.
